fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests the word at pc, hands it downstream,
// pulses the program counter and honours jump redirects and memory timeouts.
module fetch_unit #(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     pc_enable,
    output logic                     pc_load,
    output logic [ADDRESS_WIDTH-1:0] pc_address,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_read,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     mem_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     fetch_error
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_WAIT,
        S_HOLD,
        S_ADVANCE,
        S_LOAD,
        S_HALT
    } state_e;

    state_e                   state_q, state_d;
    logic                     pc_enable_q, pc_enable_d;
    logic                     pc_load_q, pc_load_d;
    logic [ADDRESS_WIDTH-1:0] pc_address_q, pc_address_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_read_q, mem_read_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic                     instr_valid_q, instr_valid_d;
    logic                     fetch_error_q, fetch_error_d;
    logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_enable_q   <= 1'b0;
            pc_load_q     <= 1'b1;
            pc_address_q  <= '0;
            mem_addr_q    <= '0;
            mem_read_q    <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_error_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_enable_q   <= pc_enable_d;
            pc_load_q     <= pc_load_d;
            pc_address_q  <= pc_address_d;
            mem_addr_q    <= mem_addr_d;
            mem_read_q    <= mem_read_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_error_q <= fetch_error_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Next-state and next-output logic; a redirect outside LOAD overrides everything
    always_comb begin
        state_d       = state_q;
        pc_enable_d   = pc_enable_q;
        pc_load_d     = pc_load_q;
        pc_address_d  = pc_address_q;
        mem_addr_d    = mem_addr_q;
        mem_read_d    = mem_read_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_error_d = fetch_error_q;
        wait_cnt_d    = wait_cnt_q;

        if (redirect && (state_q != S_LOAD)) begin
            state_d       = S_LOAD;
            pc_load_d     = 1'b0;
            pc_address_d  = redirect_target;
            mem_read_d    = 1'b0;
            instr_valid_d = 1'b0;
            pc_enable_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQUEST;
                S_REQUEST: begin
                    mem_addr_d = pc;
                    mem_read_d = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        instr_d       = mem_data;
                        instr_valid_d = 1'b1;
                        mem_read_d    = 1'b0;
                        state_d       = S_HOLD;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        if (wait_cnt_d == TIMEOUT_LIM) begin
                            fetch_error_d = 1'b1;
                            mem_read_d    = 1'b0;
                            state_d       = S_HALT;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_valid_q && instr_ready) begin
                        instr_valid_d = 1'b0;
                        pc_enable_d   = 1'b1;
                        state_d       = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    pc_enable_d = 1'b0;
                    state_d     = S_REQUEST;
                end
                S_LOAD: begin
                    pc_load_d = 1'b1;
                    state_d   = S_REQUEST;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign pc_enable   = pc_enable_q;
    assign pc_load     = pc_load_q;
    assign pc_address  = pc_address_q;
    assign mem_addr    = mem_addr_q;
    assign mem_read    = mem_read_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_error = fetch_error_q;

endmodule
